// File: rtl/comp_seq.sv
// Sequential magnitude comparator: walks A vs B one CHUNK at a time, MSB chunk first,
// with a start/busy/done handshake and registered one-hot result flags.
module comp_seq #(
  parameter int WIDTH      = 16,
  parameter int CHUNK      = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic             abort,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_gt_B,
  output logic             A_lt_B,
  output logic             A_eq_B
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [KW-1:0]    k;
  logic             decided;
  logic             rec_gt;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic             differ;
  logic             chunk_gt;
  logic             final_step;
  logic             res_gt;
  logic             res_lt;
  logic             res_eq;
  logic [WIDTH-1:0] msb_flip;

  // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
  assign msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};

  always_comb begin
    sh_a       = op_a >> (k * CHUNK);
    sh_b       = op_b >> (k * CHUNK);
    chunk_a    = sh_a[CHUNK-1:0];
    chunk_b    = sh_b[CHUNK-1:0];
    differ     = (chunk_a != chunk_b);
    chunk_gt   = (chunk_a > chunk_b);
    final_step = (k == '0) || (EARLY_EXIT && differ);
    // Once a higher chunk has decided, lower chunks cannot change the outcome.
    res_gt     = decided ? rec_gt  : (differ && chunk_gt);
    res_lt     = decided ? !rec_gt : (differ && !chunk_gt);
    res_eq     = !decided && !differ;
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      k       <= '0;
      decided <= 1'b0;
      rec_gt  <= 1'b0;
      done    <= 1'b0;
      A_gt_B  <= 1'b0;
      A_lt_B  <= 1'b0;
      A_eq_B  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          op_a    <= A ^ msb_flip;
          op_b    <= B ^ msb_flip;
          k       <= KW'(NCHUNK - 1);
          decided <= 1'b0;
          state   <= RUN;
        end
      end else if (abort) begin
        state <= IDLE;
      end else if (final_step) begin
        A_gt_B <= res_gt;
        A_lt_B <= res_lt;
        A_eq_B <= res_eq;
        done   <= 1'b1;
        state  <= IDLE;
      end else begin
        k <= k - 1'b1;
        if (differ && !decided) begin
          decided <= 1'b1;
          rec_gt  <= chunk_gt;
        end
      end
    end
  end

endmodule

// File: tb/tb_comp_seq.sv
// Self-checking bench for comp_seq: four parameterisations share one stimulus stream and are
// checked every cycle against an arithmetic reference model, plus literal directed checks.
module tb_comp_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;

  logic [3:0] busy_o, done_o, gt_o, lt_o, eq_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Per-instance parameters: 0: 16/4 early, 1: 16/4 full, 2: 4/1 early, 3: 4/4 early
  int pw [4] = '{16, 16, 4, 4};
  int pc [4] = '{4, 4, 1, 4};
  int pe [4] = '{1, 0, 1, 1};

  always #5 clk = ~clk;

  comp_seq #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode), .abort(abort),
    .A(a_in), .B(b_in), .busy(busy_o[0]), .done(done_o[0]),
    .A_gt_B(gt_o[0]), .A_lt_B(lt_o[0]), .A_eq_B(eq_o[0]));
  comp_seq #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode), .abort(abort),
    .A(a_in), .B(b_in), .busy(busy_o[1]), .done(done_o[1]),
    .A_gt_B(gt_o[1]), .A_lt_B(lt_o[1]), .A_eq_B(eq_o[1]));
  comp_seq #(.WIDTH(4), .CHUNK(1), .EARLY_EXIT(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode), .abort(abort),
    .A(a_in[3:0]), .B(b_in[3:0]), .busy(busy_o[2]), .done(done_o[2]),
    .A_gt_B(gt_o[2]), .A_lt_B(lt_o[2]), .A_eq_B(eq_o[2]));
  comp_seq #(.WIDTH(4), .CHUNK(4), .EARLY_EXIT(1'b1)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode), .abort(abort),
    .A(a_in[3:0]), .B(b_in[3:0]), .busy(busy_o[3]), .done(done_o[3]),
    .A_gt_B(gt_o[3]), .A_lt_B(lt_o[3]), .A_eq_B(eq_o[3]));

  // Reference result {gt,lt,eq} from plain integer comparison of the w-bit operands.
  function automatic logic [2:0] ref_flags(int w, logic [15:0] a, logic [15:0] b, logic sm);
    int va, vb;
    va = int'(a) & ((1 << w) - 1);
    vb = int'(b) & ((1 << w) - 1);
    if (sm && va >= (1 << (w - 1))) va = va - (1 << w);
    if (sm && vb >= (1 << (w - 1))) vb = vb - (1 << w);
    if (va > vb) return 3'b100;
    if (va < vb) return 3'b010;
    return 3'b001;
  endfunction

  // Number of chunks examined: up to and including the first differing chunk from the top.
  function automatic int ref_len(int w, int c, int ee, logic [15:0] a, logic [15:0] b);
    int n, x;
    n = w / c;
    x = int'(a ^ b) & ((1 << w) - 1);
    if (ee == 0) return n;
    for (int i = 0; i < n; i++)
      if (((x >> ((n - 1 - i) * c)) & ((1 << c) - 1)) != 0) return i + 1;
    return n;
  endfunction

  logic       m_busy [4];
  logic       m_done [4];
  logic [2:0] m_flag [4];
  logic [2:0] m_pend [4];
  int         m_rem  [4];

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_busy[i] = 1'b0; m_done[i] = 1'b0; m_flag[i] = 3'b000; m_pend[i] = 3'b000; m_rem[i] = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_flag[i] <= 3'b000; m_rem[i] <= 0;
      end else if (m_busy[i]) begin
        if (abort) begin
          m_busy[i] <= 1'b0; m_done[i] <= 1'b0;
        end else if (m_rem[i] == 1) begin
          m_busy[i] <= 1'b0; m_done[i] <= 1'b1; m_flag[i] <= m_pend[i];
        end else begin
          m_rem[i] <= m_rem[i] - 1; m_done[i] <= 1'b0;
        end
      end else begin
        m_done[i] <= 1'b0;
        if (start) begin
          m_busy[i] <= 1'b1;
          m_rem[i]  <= ref_len(pw[i], pc[i], pe[i], a_in, b_in);
          m_pend[i] <= ref_flags(pw[i], a_in, b_in, signed_mode);
        end
      end
    end
  end

  // Cycle-by-cycle compare against the model, sampled just after the active edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({busy_o[i], done_o[i], gt_o[i], lt_o[i], eq_o[i]} !==
            {m_busy[i], m_done[i], m_flag[i]}) begin
          errors++;
          $display("FAIL cyc_dut%0d t=%0t {busy,done,gt,lt,eq} actual=%b required=%b", i, $time,
                   {busy_o[i], done_o[i], gt_o[i], lt_o[i], eq_o[i]},
                   {m_busy[i], m_done[i], m_flag[i]});
        end
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy_o != 4'b0000 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("wait_idle_timeout", 1, 0);
  endtask

  // Launch one operation and count edges from start to the done pulse of instance id.
  task automatic lat(int id, logic [15:0] a, logic [15:0] b, logic sm, output int n,
                     output logic [2:0] flags);
    wait_idle();
    a_in = a; b_in = b; signed_mode = sm; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      #2;
      if (done_o[id]) break;
    end
    flags = {gt_o[id], lt_o[id], eq_o[id]};
  endtask

  int         n;
  logic [2:0] f;

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs_dut0", int'({busy_o[0], done_o[0], gt_o[0], lt_o[0], eq_o[0]}), 0);
    rst_n = 1'b1;

    // Pin the model itself with hand-computed values.
    chk("model_len_A000_9FFF", ref_len(16, 4, 1, 16'hA000, 16'h9FFF), 1);
    chk("model_len_5A5A", ref_len(16, 4, 1, 16'h5A5A, 16'h5A5A), 4);
    chk("model_flags_signed_m1_1", int'(ref_flags(16, 16'hFFFF, 16'h0001, 1'b1)), 3'b010);
    chk("model_flags_w4_signed_8_7", int'(ref_flags(4, 16'h0008, 16'h0007, 1'b1)), 3'b010);

    // Reset mid-operation.
    wait_idle();
    a_in = 16'h1234; b_in = 16'h1235; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("midrun_reset_dut1", int'({busy_o[1], done_o[1], gt_o[1], lt_o[1], eq_o[1]}), 0);
    @(negedge clk) rst_n = 1'b1;

    lat(0, 16'hA000, 16'h9FFF, 1'b0, n, f);
    chk("early_gt_edges", n, 1); chk("early_gt_flags", int'(f), 3'b100);
    lat(0, 16'h5A5A, 16'h5A5A, 1'b0, n, f);
    chk("early_eq_edges", n, 4); chk("early_eq_flags", int'(f), 3'b001);
    lat(1, 16'h0001, 16'h8000, 1'b0, n, f);
    chk("full_lt_edges", n, 4); chk("full_lt_flags", int'(f), 3'b010);
    lat(0, 16'hFFFF, 16'h0001, 1'b1, n, f);
    chk("signed_lt_flags", int'(f), 3'b010);
    lat(0, 16'hFFFF, 16'h0001, 1'b0, n, f);
    chk("unsigned_gt_flags", int'(f), 3'b100);

    // Start held high for 10 cycles with operands wandering underneath.
    wait_idle();
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_in = 16'($urandom); b_in = (i % 2 == 0) ? a_in : 16'($urandom); signed_mode = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;

    // Abort landing on the final RUN edge of an equal-operand compare.
    lat(0, 16'hA000, 16'h9FFF, 1'b0, n, f);
    wait_idle();
    a_in = 16'h5A5A; b_in = 16'h5A5A; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_final_busy", int'(busy_o[0]), 0);
    chk("abort_final_done", int'(done_o[0]), 0);
    chk("abort_flags_held", int'({gt_o[0], lt_o[0], eq_o[0]}), 3'b100);

    // Exhaustive 4-bit sweep in both modes.
    for (int sm = 0; sm < 2; sm++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          wait_idle();
          a_in = 16'(a); b_in = 16'(b); signed_mode = 1'(sm); start = 1'b1;
          @(negedge clk) start = 1'b0;
        end
    wait_idle();

    // Randomised traffic with occasional abort and reset.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst_n       = ($urandom_range(0, 299) != 0);
      start       = 1'($urandom);
      abort       = ($urandom_range(0, 15) == 0);
      signed_mode = 1'($urandom);
      a_in        = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b_in = 16'($urandom);
        1: b_in = a_in;
        2: b_in = a_in ^ (16'h1 << $urandom_range(0, 15));
        default: b_in = {a_in[15:4], 4'($urandom)};
      endcase
    end
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
